// File: rtl/bram_stream_reader.sv
// Read-side controller for a simple-dual-port byte BRAM: plays back a block of bytes from port B
// onto a valid/ready stream, with a small FIFO absorbing the one-cycle BRAM read latency.
module bram_stream_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              enb_o,
    output logic [ADDR_W-1:0] addrb_o,
    input  logic [DATA_W-1:0] doutb_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              enb_q;
    logic              capture_q;
    logic [ADDR_W-1:0] addrb_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   popped_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W:0]    committed;
    logic              pop;
    logic              issue_ok;
    logic              final_beat;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign enb_o     = enb_q;
    assign addrb_o   = addrb_q;
    assign m_valid_o = (occ_q != '0);
    assign m_data_o  = m_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign m_last_o  = m_valid_o && (popped_q == len_q - CNT_ONE);

    // A read may only be issued if every byte already owed to the FIFO (stored, arriving
    // from the BRAM now, or requested this cycle) still leaves room for one more.
    always_comb begin
        committed  = {1'b0, occ_q} + (OCC_W+1)'(capture_q) + (OCC_W+1)'(enb_q);
        issue_ok   = (state_q == RUN) && (issued_q < len_q)
                     && (committed < (OCC_W+1)'(FIFO_DEPTH));
        pop        = m_valid_o && m_ready_i;
        final_beat = pop && (popped_q == len_q - CNT_ONE);
        wr_ptr_d   = wr_ptr_q + PTR_W'(capture_q);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        occ_d      = occ_q + OCC_W'(capture_q) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            enb_q     <= 1'b0;
            capture_q <= 1'b0;
            addrb_q   <= '0;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            enb_q     <= 1'b0;
            capture_q <= enb_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            if (pop) begin
                popped_q <= popped_q + CNT_ONE;
            end
            case (state_q)
                // The first read goes out on the accepting edge so enb rises the very next cycle.
                IDLE: begin
                    if (start_i) begin
                        base_q   <= base_addr_i;
                        len_q    <= length_i;
                        popped_q <= '0;
                        if (length_i != '0) begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            enb_q    <= 1'b1;
                            addrb_q  <= base_addr_i;
                            issued_q <= CNT_ONE;
                        end else begin
                            issued_q <= '0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_ok) begin
                        enb_q    <= 1'b1;
                        addrb_q  <= base_q + issued_q[ADDR_W-1:0];
                        issued_q <= issued_q + CNT_ONE;
                    end
                    if (final_beat) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (capture_q && !rst) begin
            fifo_mem[wr_ptr_q] <= doutb_i;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a behavioural BRAM on port B and a scoreboard of expected
// stream bytes filled when each transfer is started.
module tb_bram_stream_reader;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int MEM_SIZE = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    logic [DATA_W-1:0] mem [MEM_SIZE];

    logic [DATA_W-1:0] sbData[$];
    bit                sbLast[$];
    logic [DATA_W-1:0] obsData[$];
    logic              obsLast[$];
    int                obsAddr[$];

    int checks = 0;
    int errors = 0;

    int enbCount, firstEnb, firstValid, lastCycle, lastCount, doneCycle, maxOut, holdBad;
    bit ended, busyAtDone, busyFirst;

    bram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .base_addr_i(base_addr),
        .length_i(length),
        .busy_o(busy),
        .done_o(done),
        .enb_o(enb),
        .addrb_o(addrb),
        .doutb_i(doutb),
        .m_valid_o(m_valid),
        .m_data_o(m_data),
        .m_last_o(m_last),
        .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;

    // Port B of the BRAM: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (enb) doutb <= mem[addrb];
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the following cycle.
    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        logic [ADDR_W-1:0] a;
        start = 1'b1;
        base_addr = b;
        length = n;
        for (int i = 0; i < int'(n); i++) begin
            a = b + ADDR_W'(i);
            sbData.push_back(mem[a]);
            sbLast.push_back(i == int'(n) - 1);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records what the DUT does cycle by cycle until done or the cycle budget runs out.
    task automatic collect(input int readyPct, input int maxCycles, input int pulseAt,
                           input logic [ADDR_W-1:0] pulseBase, input logic [ADDR_W:0] pulseLen);
        int popCount;
        bit holdPending;
        logic [DATA_W-1:0] holdData;
        logic holdLast;
        obsData.delete(); obsLast.delete(); obsAddr.delete();
        enbCount = 0; firstEnb = -1; firstValid = -1; lastCycle = -1; lastCount = 0;
        doneCycle = -1; maxOut = 0; holdBad = 0; ended = 0; busyAtDone = 0; busyFirst = 0;
        popCount = 0; holdPending = 0; holdData = '0; holdLast = 1'b0;
        for (int c = 1; c <= maxCycles; c++) begin
            m_ready = (readyPct >= 100) ? 1'b1 : ($urandom_range(99) < readyPct);
            if (c == pulseAt) begin
                start = 1'b1; base_addr = pulseBase; length = pulseLen;
            end else begin
                start = 1'b0;
            end
            if (c == 1) busyFirst = busy;
            if (enb) begin
                enbCount++;
                obsAddr.push_back(int'(addrb));
                if (firstEnb < 0) firstEnb = c;
                if (enbCount - popCount > maxOut) maxOut = enbCount - popCount;
            end
            if (holdPending && (!m_valid || m_data !== holdData || m_last !== holdLast)) holdBad++;
            if (m_valid && firstValid < 0) firstValid = c;
            if (m_valid && m_ready) begin
                obsData.push_back(m_data);
                obsLast.push_back(m_last);
                popCount++;
                if (m_last) begin lastCount++; lastCycle = c; end
            end
            holdPending = m_valid && !m_ready;
            holdData = m_data;
            holdLast = m_last;
            if (done) begin
                doneCycle = c; busyAtDone = busy; ended = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] expD, gotD;
        bit expL;
        logic gotL;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, enb, addrb, m_valid, m_data, m_last} !== '0) begin
            errors++;
            $display("[TB] FAIL power_on_reset: got busy=%b done=%b enb=%b addrb=%0d valid=%b data=%h last=%b, required all 0",
                     busy, done, enb, addrb, m_valid, m_data, m_last);
        end
        rst = 1'b0;
        @(negedge clk);
        do_start(11'd10, 12'd20);
        collect(100, 6, 0, '0, '0);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_setup_running: got m_valid=%b, required 1", m_valid);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, enb, addrb, m_valid, m_data, m_last} !== '0) begin
                errors++;
                $display("[TB] FAIL mid_run_reset%0d: got busy=%b done=%b enb=%b addrb=%0d valid=%b data=%h last=%b, required all 0",
                         k, busy, done, enb, addrb, m_valid, m_data, m_last);
            end
        end
        rst = 1'b0;
        sbData.delete(); sbLast.delete();
        @(negedge clk);
        do_start(11'd10, 12'd5);
        collect(100, 50, 0, '0, '0);
        checks++;
        if (!ended || obsData.size() != 5 || enbCount != 5) begin
            errors++;
            $display("[TB] FAIL post_reset_run: got ended=%b bytes=%0d reads=%0d, required 1/5/5",
                     ended, obsData.size(), enbCount);
        end
        for (int i = 0; i < obsAddr.size(); i++) begin
            checks++;
            if (obsAddr[i] != 10 + i) begin
                errors++;
                $display("[TB] FAIL post_reset_addr%0d: got %0d, required %0d", i, obsAddr[i], 10 + i);
            end
        end
        while (obsData.size() > 0 && sbData.size() > 0) begin
            expD = sbData.pop_front(); expL = sbLast.pop_front();
            gotD = obsData.pop_front(); gotL = obsLast.pop_front();
            checks++;
            if (gotD !== expD || gotL !== expL) begin
                errors++;
                $display("[TB] FAIL post_reset_byte: got data=%h last=%b, required data=%h last=%b", gotD, gotL, expD, expL);
            end
        end
        sbData.delete(); sbLast.delete();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] expD, gotD;
        bit expL;
        logic gotL;
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        do_start(11'd0, 12'd4);
        collect(100, 20, 0, '0, '0);
        checks++;
        if (busyFirst !== 1'b1 || firstEnb != 1 || enbCount != 4) begin
            errors++;
            $display("[TB] FAIL basic_issue: got busy@T+1=%b firstEnb=T+%0d reads=%0d, required 1/T+1/4", busyFirst, firstEnb, enbCount);
        end
        for (int i = 0; i < obsAddr.size(); i++) begin
            checks++;
            if (obsAddr[i] != i) begin
                errors++;
                $display("[TB] FAIL basic_addr%0d: got %0d, required %0d", i, obsAddr[i], i);
            end
        end
        checks++;
        if (firstValid != 3 || lastCycle != 6 || lastCount != 1) begin
            errors++;
            $display("[TB] FAIL basic_timing: got firstValid=T+%0d last=T+%0d lastCount=%0d, required T+3/T+6/1", firstValid, lastCycle, lastCount);
        end
        checks++;
        if (doneCycle != 7 || busyAtDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: got done=T+%0d busy=%b, required T+7/0", doneCycle, busyAtDone);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: got done=%b one cycle later, required 0", done);
        end
        checks++;
        if (obsData.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d bytes, required 4", obsData.size());
        end
        while (obsData.size() > 0 && sbData.size() > 0) begin
            expD = sbData.pop_front(); expL = sbLast.pop_front();
            gotD = obsData.pop_front(); gotL = obsLast.pop_front();
            checks++;
            if (gotD !== expD || gotL !== expL) begin
                errors++;
                $display("[TB] FAIL basic_byte: got data=%h last=%b, required data=%h last=%b", gotD, gotL, expD, expL);
            end
        end
        sbData.delete(); sbLast.delete();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] expD, gotD;
        bit expL;
        logic gotL;
        for (int r = 0; r < 2; r++) begin
            do_start(11'd100 + ADDR_W'(r * 40), 12'd16);
            collect(50, 400, 0, '0, '0);
            checks++;
            if (!ended || obsData.size() != 16 || enbCount != 16) begin
                errors++;
                $display("[TB] FAIL bp_count%0d: got ended=%b bytes=%0d reads=%0d, required 1/16/16", r, ended, obsData.size(), enbCount);
            end
            checks++;
            if (holdBad != 0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got %0d unstable stalled cycles, required 0", r, holdBad);
            end
            checks++;
            if (maxOut > DEPTH) begin
                errors++;
                $display("[TB] FAIL bp_credit%0d: got %0d bytes outstanding, required <= %0d", r, maxOut, DEPTH);
            end
            while (obsData.size() > 0 && sbData.size() > 0) begin
                expD = sbData.pop_front(); expL = sbLast.pop_front();
                gotD = obsData.pop_front(); gotL = obsLast.pop_front();
                checks++;
                if (gotD !== expD || gotL !== expL) begin
                    errors++;
                    $display("[TB] FAIL bp_byte%0d: got data=%h last=%b, required data=%h last=%b", r, gotD, gotL, expD, expL);
                end
            end
            sbData.delete(); sbLast.delete();
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] expD, gotD;
        bit expL;
        logic gotL;
        int expAddr [4];
        expAddr = '{2046, 2047, 0, 1};
        do_start(11'd2046, 12'd4);
        collect(100, 30, 0, '0, '0);
        checks++;
        if (!ended || obsAddr.size() != 4 || obsData.size() != 4) begin
            errors++;
            $display("[TB] FAIL wrap_count: got ended=%b reads=%0d bytes=%0d, required 1/4/4", ended, obsAddr.size(), obsData.size());
        end
        for (int i = 0; i < 4 && i < obsAddr.size(); i++) begin
            checks++;
            if (obsAddr[i] != expAddr[i]) begin
                errors++;
                $display("[TB] FAIL wrap_addr%0d: got %0d, required %0d", i, obsAddr[i], expAddr[i]);
            end
        end
        while (obsData.size() > 0 && sbData.size() > 0) begin
            expD = sbData.pop_front(); expL = sbLast.pop_front();
            gotD = obsData.pop_front(); gotL = obsLast.pop_front();
            checks++;
            if (gotD !== expD || gotL !== expL) begin
                errors++;
                $display("[TB] FAIL wrap_byte: got data=%h last=%b, required data=%h last=%b", gotD, gotL, expD, expL);
            end
        end
        sbData.delete(); sbLast.delete();
    endtask

    task automatic test_corners();
        logic [DATA_W-1:0] expD, gotD;
        bit expL;
        logic gotL;
        do_start(11'd77, 12'd0);
        collect(100, 20, 0, '0, '0);
        checks++;
        if (doneCycle != 1 || enbCount != 0 || obsData.size() != 0 || busyFirst !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_length: got done=T+%0d reads=%0d bytes=%0d busy=%b, required T+1/0/0/0",
                     doneCycle, enbCount, obsData.size(), busyFirst);
        end
        do_start(11'd5, 12'd2048);
        collect(100, 2200, 0, '0, '0);
        checks++;
        if (!ended || obsData.size() != 2048 || enbCount != 2048 || lastCount != 1 || lastCycle != firstValid + 2047) begin
            errors++;
            $display("[TB] FAIL full_length: got ended=%b bytes=%0d reads=%0d lastCount=%0d lastOffset=%0d, required 1/2048/2048/1/2047",
                     ended, obsData.size(), enbCount, lastCount, lastCycle - firstValid);
        end
        while (obsData.size() > 0 && sbData.size() > 0) begin
            expD = sbData.pop_front(); expL = sbLast.pop_front();
            gotD = obsData.pop_front(); gotL = obsLast.pop_front();
            checks++;
            if (gotD !== expD || gotL !== expL) begin
                errors++;
                $display("[TB] FAIL full_byte: got data=%h last=%b, required data=%h last=%b", gotD, gotL, expD, expL);
            end
        end
        sbData.delete(); sbLast.delete();
        do_start(11'd300, 12'd10);
        collect(100, 100, 3, 11'd0, 12'd7);
        checks++;
        if (!ended || obsData.size() != 10 || enbCount != 10 || obsAddr[0] != 300 || obsAddr[obsAddr.size()-1] != 309) begin
            errors++;
            $display("[TB] FAIL start_while_busy: got ended=%b bytes=%0d reads=%0d, required 1/10/10 over 300..309",
                     ended, obsData.size(), enbCount);
        end
        while (obsData.size() > 0 && sbData.size() > 0) begin
            expD = sbData.pop_front(); expL = sbLast.pop_front();
            gotD = obsData.pop_front(); gotL = obsLast.pop_front();
            checks++;
            if (gotD !== expD || gotL !== expL) begin
                errors++;
                $display("[TB] FAIL busy_start_byte: got data=%h last=%b, required data=%h last=%b", gotD, gotL, expD, expL);
            end
        end
        sbData.delete(); sbLast.delete();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || enb !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_ignore%0d: got busy=%b enb=%b valid=%b, required 0/0/0", k, busy, enb, m_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_ready = 1'b1;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = DATA_W'($urandom);
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
